cla64_result_checker: RTL

- Hardware consumer for the cla64 test-vector stream: accepts one {a, b, cin, z, cout} vector per handshake.
- Recomputes the expected 65-bit sum a+b+cin in a two-stage, 32-bit-split pipeline.
- Compares the expected sum with the DUT result, counts vectors and errors, and captures the first mismatch.
- Sits at the receiving end of the vector source, in place of file output. Raises done after NUM_TESTS vectors.

---
 rtl/cla64_chk_pkg.sv | 18 +
 rtl/cla64_result_checker_half.sv | 15 +
 rtl/cla64_result_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cla64_chk_pkg.sv
// Shared types for the cla64 result checker.
// Counter width, vector bundle and {cout, sum} result type.
package cla64_chk_pkg;

    localparam int CNT_W = 32;
    localparam int VEC_W = 64;

    typedef struct packed {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
        logic             cin;
        logic [VEC_W-1:0] z;
        logic             cout;
    } vec_t;

    typedef logic [VEC_W:0] res_t;

endpackage

// File: rtl/cla64_result_checker_half.sv
// Reference half-width adder with explicit carry in and out.
// Used once for the low half and once for the high half.
module cla_half_adder_ref #(
    parameter int HW = 32
) (
    input  logic [HW-1:0] i_a,
    input  logic [HW-1:0] i_b,
    input  logic          i_cin,
    output logic [HW-1:0] o_sum,
    output logic          o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{HW{1'b0}}, i_cin};

endmodule

// File: rtl/cla64_result_checker.sv
// Consumes {a, b, cin, z, cout} vectors, recomputes a+b+cin in two
// 32-bit halves and tallies vectors, errors and the first mismatch.
module cla64_result_checker
    import cla64_chk_pkg::*;
#(
    parameter int NUM_TESTS = 64,
    parameter int WIDTH     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_cout,
    output logic [CNT_W-1:0] vector_count,
    output logic [CNT_W-1:0] error_count,
    output logic             err_flag,
    output logic [CNT_W-1:0] first_err_vec,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got,
    output logic             done
);

    localparam int H = WIDTH / 2;
    localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_TESTS);

    logic [CNT_W-1:0] r_acc_cnt;
    logic             w_acc;

    logic             r_s1_v;
    logic [CNT_W-1:0] r_s1_idx;
    logic [H-1:0]     r_s1_a_hi;
    logic [H-1:0]     r_s1_b_hi;
    logic [WIDTH-1:0] r_s1_z;
    logic             r_s1_cout;
    logic [H-1:0]     r_s1_slo;
    logic             r_s1_clo;

    logic [H-1:0]     w_slo;
    logic             w_clo;
    logic [H-1:0]     w_shi;
    logic             w_chi;
    logic [WIDTH:0]   w_exp;
    logic [WIDTH:0]   w_got;

    logic             r_s2_v;
    logic [CNT_W-1:0] r_s2_idx;
    logic [WIDTH:0]   r_s2_exp;
    logic [WIDTH:0]   r_s2_got;
    logic             r_s2_mis;

    logic [CNT_W-1:0] r_vcnt;
    logic [CNT_W-1:0] r_ecnt;
    logic             r_err;
    logic [CNT_W-1:0] r_fvec;
    logic [WIDTH:0]   r_fexp;
    logic [WIDTH:0]   r_fgot;
    logic             r_done;
    logic [CNT_W-1:0] w_vcnt_nxt;

    assign in_ready   = !clear && (r_acc_cnt < LP_NUM);
    assign w_acc      = in_valid && in_ready;
    assign w_vcnt_nxt = r_vcnt + CNT_W'(1);

    cla_half_adder_ref #(.HW(H)) u_lo (
        .i_a    (in_a[H-1:0]),
        .i_b    (in_b[H-1:0]),
        .i_cin  (in_cin),
        .o_sum  (w_slo),
        .o_cout (w_clo)
    );

    cla_half_adder_ref #(.HW(H)) u_hi (
        .i_a    (r_s1_a_hi),
        .i_b    (r_s1_b_hi),
        .i_cin  (r_s1_clo),
        .o_sum  (w_shi),
        .o_cout (w_chi)
    );

    assign w_exp = {w_chi, w_shi, r_s1_slo};
    assign w_got = {r_s1_cout, r_s1_z};

    // Stage 1: accept a vector and register the low-half sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_cnt <= '0;
            r_s1_v    <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_a_hi <= '0;
            r_s1_b_hi <= '0;
            r_s1_z    <= '0;
            r_s1_cout <= 1'b0;
            r_s1_slo  <= '0;
            r_s1_clo  <= 1'b0;
        end else if (clear) begin
            r_acc_cnt <= '0;
            r_s1_v    <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_a_hi <= '0;
            r_s1_b_hi <= '0;
            r_s1_z    <= '0;
            r_s1_cout <= 1'b0;
            r_s1_slo  <= '0;
            r_s1_clo  <= 1'b0;
        end else begin
            r_s1_v <= w_acc;
            if (w_acc) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                r_s1_idx  <= r_acc_cnt;
                r_s1_a_hi <= in_a[WIDTH-1:H];
                r_s1_b_hi <= in_b[WIDTH-1:H];
                r_s1_z    <= in_z;
                r_s1_cout <= in_cout;
                r_s1_slo  <= w_slo;
                r_s1_clo  <= w_clo;
            end
        end
    end

    // Stage 2: finish the high half and register the compare result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_v   <= 1'b0;
            r_s2_idx <= '0;
            r_s2_exp <= '0;
            r_s2_got <= '0;
            r_s2_mis <= 1'b0;
        end else if (clear) begin
            r_s2_v   <= 1'b0;
            r_s2_idx <= '0;
            r_s2_exp <= '0;
            r_s2_got <= '0;
            r_s2_mis <= 1'b0;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_idx <= r_s1_idx;
                r_s2_exp <= w_exp;
                r_s2_got <= w_got;
                r_s2_mis <= (w_exp != w_got);
            end
        end
    end

    // Tally results, capture the first mismatch and raise done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vcnt <= '0;
            r_ecnt <= '0;
            r_err  <= 1'b0;
            r_fvec <= '0;
            r_fexp <= '0;
            r_fgot <= '0;
            r_done <= 1'b0;
        end else if (clear) begin
            r_vcnt <= '0;
            r_ecnt <= '0;
            r_err  <= 1'b0;
            r_fvec <= '0;
            r_fexp <= '0;
            r_fgot <= '0;
            r_done <= 1'b0;
        end else begin
            if (r_s2_v) begin
                r_vcnt <= w_vcnt_nxt;
                if (w_vcnt_nxt == LP_NUM) begin
                    r_done <= 1'b1;
                end
                if (r_s2_mis && (r_ecnt != '1)) begin
                    r_ecnt <= r_ecnt + CNT_W'(1);
                end
                if (r_s2_mis && !r_err) begin
                    r_err  <= 1'b1;
                    r_fvec <= r_s2_idx;
                    r_fexp <= r_s2_exp;
                    r_fgot <= r_s2_got;
                end
            end
            if (NUM_TESTS == 0) begin
                r_done <= 1'b1;
            end
        end
    end

    assign vector_count  = r_vcnt;
    assign error_count   = r_ecnt;
    assign err_flag      = r_err;
    assign first_err_vec = r_fvec;
    assign first_err_exp = r_fexp;
    assign first_err_got = r_fgot;
    assign done          = r_done;

endmodule
